// File: rtl/root_issue_queue.sv
// Request FIFO and one-at-a-time issue sequencer in front of the k-th root engine.
// Optional feature: define ROOTQ_EXP1_BYPASS_EN to answer exponent-1 requests locally.
module root_issue_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_data_1,
    input  logic [2:0]  in_data_2,
    output logic        root_in_valid,
    output logic [9:0]  root_data_1,
    output logic [2:0]  root_data_2,
    input  logic        root_out_valid,
    input  logic [19:0] root_out_data,
    output logic        out_valid,
    output logic [19:0] out_data,
    output logic [2:0]  out_exp,
    output logic        err_exp0
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    logic [12:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [12:0]      head;
    logic             accept;
    logic             push;
    logic             pop;
    logic             capture;
    logic             bypass;

    assign in_ready = (count != FULL_CNT);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (in_data_2 != 3'd0);
    assign head     = mem[rd_ptr];

`ifdef ROOTQ_EXP1_BYPASS_EN
    assign bypass = (head[2:0] == 3'd1);
`else
    assign bypass = 1'b0;
`endif

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_data_1, in_data_2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop && !bypass) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (root_out_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop           = (state == IDLE) && (count != '0);
        root_in_valid = (state == ISSUE);
        capture       = (state == WAIT) && root_out_valid;
    end

    // Hold registers stay put from the pop edge until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_data_1 <= '0;
            root_data_2 <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_exp     <= '0;
            err_exp0    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_exp   <= '0;
            err_exp0  <= accept && (in_data_2 == 3'd0);
            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= root_out_data;
                out_exp   <= root_data_2;
            end else if (pop && bypass) begin
                out_valid <= 1'b1;
                out_data  <= {head[12:3], 10'b0};
                out_exp   <= 3'd1;
            end
            if (pop) begin
                root_data_1 <= head[12:3];
                root_data_2 <= head[2:0];
            end
        end
    end

endmodule
